mux_2x1_rr_arbiter: RTL
=======================

Name: mux_2x1_rr_arbiter

Overview:
Two-requester round-robin arbiter that shares one 2:1 mux datapath and one downstream channel between two streaming sources. It holds a grant per packet (until a `last` beat) with an optional beat cap for fairness, and drives the mux select from the grant state. The mux output is registered into a single-entry valid/ready output stage. It sits between two producer blocks and one consumer.

Parameters:
- DATA_W, 8: width of each requester's data and of out_data.
- MAX_BEATS, 0: maximum beats per grant before forced release. 0 disables the cap; otherwise it must be ≥1.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req0_valid, input, 1: requester 0 has a beat.
- req0_data, input, DATA_W: requester 0 beat data.
- req0_last, input, 1: the beat is the final beat of a packet.
- req0_ready, output, 1: requester 0 beat accepted this cycle when high with req0_valid.
- req1_valid, input, 1: as req0_valid, for requester 1.
- req1_data, input, DATA_W: as req0_data, for requester 1.
- req1_last, input, 1: as req0_last, for requester 1.
- req1_ready, output, 1: as req0_ready, for requester 1.
- out_valid, output, 1: output register holds a beat.
- out_data, output, DATA_W: registered mux output.
- out_last, output, 1: registered copy of the accepted beat's last.
- out_src, output, 1: source of the held beat (0 = req0, 1 = req1).
- out_ready, input, 1: consumer accepts when high with out_valid.
- sel, output, 1: mux select; 1 only in state GRANT1.

Behaviour:
- Reset (rst_n low, async): state = IDLE, rr_ptr = 0 (req0 favoured), beat_cnt = 0, out_valid = 0, out_data = 0, out_last = 0, out_src = 0. During reset, req0_ready = req1_ready = 0 and sel = 0.
- Reset mid-packet drops any in-flight beat; there is no recovery of partial packets.
- load_en = !out_valid | out_ready (output slot free or draining this cycle).
- State IDLE:
  - reqX_ready = 0.
  - Only req0_valid → GRANT0. Only req1_valid → GRANT1.
  - Both valid → GRANT(rr_ptr).
  - Neither valid → stay in IDLE.
  - No beat is transferred in IDLE, so there is a one-cycle arbitration bubble per grant.
- State GRANTk:
  - reqk_ready = load_en; the other requester's ready = 0.
  - Transfer = reqk_valid & reqk_ready. On transfer: out_data ← reqk_data, out_last ← reqk_last, out_src ← k, out_valid ← 1, and beat_cnt increments.
  - Release occurs on a transfer with reqk_last = 1, or (MAX_BEATS ≠ 0) on a transfer where beat_cnt == MAX_BEATS-1.
  - On release: next state = IDLE, rr_ptr ← ~k, beat_cnt ← 0.
  - A forced release does not alter out_last; the remainder of the packet re-arbitrates.
  - reqk_valid low while granted: hold the grant and wait; there is no timeout.
- Output register:
  - No transfer and out_ready = 1 → out_valid ← 0.
  - No transfer and out_ready = 0 → hold all output fields stable.
  - Simultaneous drain and load in the same cycle → new beat replaces the old one; out_valid stays 1.
  - Full throughput within a grant is one beat per cycle while out_ready = 1.
- sel = (state == GRANT1). The output datapath is sel ? req1_data : req0_data, captured only on transfer.
- beat_cnt is wide enough to hold MAX_BEATS-1 (minimum 1 bit) and never wraps while granted.
- Simultaneous new requests while granted are ignored until the return to IDLE.

Test Plan:
- Reset: assert rst_n = 0 mid-transfer with out_valid = 1 → out_valid, out_data, out_src and sel all 0 immediately (async); after release, the first grant goes to req0.
- Single requester: req1 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), out_ready = 1 → sel = 1 from cycle 1; out_data shows 0x11/0x22/0x33 on consecutive cycles with out_src = 1 and out_last only on 0x33; then IDLE.
- Contention and fairness: both requesters continuously send 2-beat packets (req0 0xA0/0xA1, req1 0xB0/0xB1) → output order is A0, A1, B0, B1, A0, A1…, with one bubble between packets.
- Backpressure: hold out_ready = 0 for 4 cycles with a beat held → out_data and out_valid stable, reqk_ready = 0. After out_ready rises, the beat drains and the next beat loads in the same cycle with no loss or duplication.
- Beat cap: MAX_BEATS = 2, req0 sends a 5-beat packet while req1 is pending → req0 beats 1–2, then req1's packet, then req0 beats 3–4, then req1, then req0 beat 5. out_last is set only on beat 5.
- Stalled grant: req0 is granted and drops req0_valid for 3 cycles while req1 is valid → state stays GRANT0, sel = 0, req1_ready = 0; req0 resumes and completes its packet.

Source files
------------

// File: rtl/mux_2x1_rr_arbiter.sv
// mux_2x1_rr_arbiter
// Two-requester round-robin arbiter driving a shared 2:1 data mux into a
// single-entry valid/ready output register. A grant is held for a whole
// packet (until a beat with last=1) or until MAX_BEATS beats have been
// accepted, whichever comes first; the other requester is favoured next.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req0_valid/data/last/ready      requester 0 stream
//   req1_valid/data/last/ready      requester 1 stream
//   out_valid/data/last/src/ready   registered output stream, out_src = origin
//   sel                             mux select, high only while requester 1 is granted
//
// state  | meaning
// IDLE   | no grant; arbitrate between pending requesters (no beat moves)
// GRANT0 | requester 0 owns the mux until last beat or beat cap
// GRANT1 | requester 1 owns the mux until last beat or beat cap

module mux_2x1_rr_arbiter #(
   parameter int DATA_W    = 8,
   parameter int MAX_BEATS = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_last,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_last,
   output logic              req1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_src,
   input  logic              out_ready,
   output logic              sel
);

   localparam int               CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BEATS > 0) ? (MAX_BEATS - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit               CAP_EN   = (MAX_BEATS != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t            state;
   logic              rr_ptr;
   logic [CNT_W-1:0]  beat_cnt;

   logic              load_en;
   logic              gnt_valid;
   logic              gnt_last;
   logic [DATA_W-1:0] gnt_data;
   logic              xfer;
   logic              cap_hit;
   logic              release_gnt;

   always_comb begin
      load_en     = !out_valid || out_ready;
      sel         = (state == GRANT1);
      req0_ready  = (state == GRANT0) && load_en;
      req1_ready  = (state == GRANT1) && load_en;
      gnt_valid   = sel ? req1_valid : req0_valid;
      gnt_last    = sel ? req1_last  : req0_last;
      gnt_data    = sel ? req1_data  : req0_data;
      // ready is only ever high for the granted side, so this is the handshake
      xfer        = gnt_valid && (req0_ready || req1_ready);
      cap_hit     = CAP_EN && (beat_cnt == CNT_LAST);
      release_gnt = xfer && (gnt_last || cap_hit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid && (!req1_valid || !rr_ptr)) begin
                  state <= GRANT0;
               end else if (req1_valid) begin
                  state <= GRANT1;
               end
            end
            GRANT0, GRANT1: begin
               if (release_gnt) begin
                  state    <= IDLE;
                  rr_ptr   <= !sel;
                  beat_cnt <= '0;
               end else if (xfer && (beat_cnt != '1)) begin
                  // saturate so an uncapped long packet cannot wrap the count
                  beat_cnt <= beat_cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase

         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_last  <= gnt_last;
            out_src   <= sel;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
